// File: rtl/video_tmds_encoder.sv
`timescale 1ns/1ps
// DVI/TMDS pixel encoder: colour reduction, transition minimising (stage 1) and DC balancing (stage 2).
// Build option: define VIDEO_TMDS_ROUND_EN to round-half-up/saturate wide colours instead of truncating.
module video_tmds_encoder #(
   parameter int COLSPC = 10
) (
   input  logic              video_clk_pix,
   input  logic              video_rst_n,
   input  logic              video_enable,
   input  logic              hsync,
   input  logic              vsync,
   input  logic [COLSPC-1:0] red,
   input  logic [COLSPC-1:0] green,
   input  logic [COLSPC-1:0] blue,
   output logic [9:0]        tmds_red,
   output logic [9:0]        tmds_green,
   output logic [9:0]        tmds_blue,
   output logic              tmds_de
);

   localparam int SH     = COLSPC - 8;
   localparam int RND_SH = (COLSPC > 8) ? COLSPC - 9 : 0;

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   function automatic logic [7:0] reduce_color(input logic [COLSPC-1:0] c);
      logic [7:0] r;
`ifdef VIDEO_TMDS_ROUND_EN
      logic [COLSPC:0] half;
      logic [COLSPC:0] sum;
      half         = '0;
      half[RND_SH] = 1'b1;
      sum          = ({1'b0, c} + half) >> SH;
      if (COLSPC == 8)
         r = c[COLSPC-1 -: 8];
      else if (|sum[COLSPC:8])
         r = 8'hFF;
      else
         r = sum[7:0];
`else
      r = c[COLSPC-1 -: 8];
`endif
      return r;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [8:0] min_transition(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] qm;
      n1       = popcount8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm       = '0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~use_xnor;
      return qm;
   endfunction

   function automatic logic [9:0] ctl_token(input logic [1:0] ctl);
      logic [9:0] t;
      case (ctl)
         2'b00:   t = TOK_00;
         2'b01:   t = TOK_01;
         2'b10:   t = TOK_10;
         default: t = TOK_11;
      endcase
      return t;
   endfunction

   // Channel index 0 = blue (carries sync), 1 = green, 2 = red.
   logic [2:0][COLSPC-1:0] pix_c;
   logic [2:0][8:0]        qm_p1_d, qm_p1_q;
   logic [2:0][3:0]        n1_p1_d, n1_p1_q;
   logic [2:0][3:0]        n0_p1_d, n0_p1_q;
   logic                   de_p1_q, hs_p1_q, vs_p1_q;
   logic [2:0][9:0]        sym_p2_d, sym_p2_q;
   logic signed [4:0]      cnt_d [3];
   logic signed [4:0]      cnt_q [3];
   logic signed [4:0]      disp_c [3];
   logic                   de_p2_q;

   assign pix_c = {red, green, blue};

   // Stage 1: reduce colour and choose XOR/XNOR chain
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         qm_p1_d[ch] = min_transition(reduce_color(pix_c[ch]));
         n1_p1_d[ch] = popcount8(qm_p1_d[ch][7:0]);
         n0_p1_d[ch] = 4'd8 - n1_p1_d[ch];
      end
   end

   // Stage 2: DC balance against running disparity, or control token when blanking
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         sym_p2_d[ch] = TOK_00;
         cnt_d[ch]    = cnt_q[ch];
         disp_c[ch]   = $signed({1'b0, n1_p1_q[ch]}) - $signed({1'b0, n0_p1_q[ch]});
         if (!de_p1_q) begin
            sym_p2_d[ch] = (ch == 0) ? ctl_token({vs_p1_q, hs_p1_q}) : TOK_00;
            cnt_d[ch]    = 5'sd0;
         end else if ((cnt_q[ch] == 5'sd0) || (disp_c[ch] == 5'sd0)) begin
            sym_p2_d[ch] = {~qm_p1_q[ch][8], qm_p1_q[ch][8],
                            qm_p1_q[ch][8] ? qm_p1_q[ch][7:0] : ~qm_p1_q[ch][7:0]};
            cnt_d[ch]    = qm_p1_q[ch][8] ? (cnt_q[ch] + disp_c[ch]) : (cnt_q[ch] - disp_c[ch]);
         end else if (((cnt_q[ch] > 5'sd0) && (disp_c[ch] > 5'sd0)) ||
                      ((cnt_q[ch] < 5'sd0) && (disp_c[ch] < 5'sd0))) begin
            sym_p2_d[ch] = {1'b1, qm_p1_q[ch][8], ~qm_p1_q[ch][7:0]};
            cnt_d[ch]    = cnt_q[ch] + (qm_p1_q[ch][8] ? 5'sd2 : 5'sd0) - disp_c[ch];
         end else begin
            sym_p2_d[ch] = {1'b0, qm_p1_q[ch][8], qm_p1_q[ch][7:0]};
            cnt_d[ch]    = cnt_q[ch] - (qm_p1_q[ch][8] ? 5'sd0 : 5'sd2) + disp_c[ch];
         end
      end
   end

   always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
      if (!video_rst_n) begin
         qm_p1_q  <= '0;
         n1_p1_q  <= '0;
         n0_p1_q  <= '0;
         de_p1_q  <= 1'b0;
         hs_p1_q  <= 1'b0;
         vs_p1_q  <= 1'b0;
         sym_p2_q <= {3{TOK_00}};
         de_p2_q  <= 1'b0;
         for (int ch = 0; ch < 3; ch++)
            cnt_q[ch] <= 5'sd0;
      end else begin
         qm_p1_q  <= qm_p1_d;
         n1_p1_q  <= n1_p1_d;
         n0_p1_q  <= n0_p1_d;
         de_p1_q  <= video_enable;
         hs_p1_q  <= hsync;
         vs_p1_q  <= vsync;
         sym_p2_q <= sym_p2_d;
         de_p2_q  <= de_p1_q;
         for (int ch = 0; ch < 3; ch++)
            cnt_q[ch] <= cnt_d[ch];
      end
   end

   assign tmds_blue  = sym_p2_q[0];
   assign tmds_green = sym_p2_q[1];
   assign tmds_red   = sym_p2_q[2];
   assign tmds_de    = de_p2_q;

endmodule

// File: tb/tb_video_tmds_encoder.sv
`timescale 1ns/1ps
// Directed-vector and reference-model bench for video_tmds_encoder at COLSPC = 10.
module tb_video_tmds_encoder;

   localparam int CW = 10;
   localparam logic [9:0] T00 = 10'h354;
   localparam logic [9:0] T01 = 10'h0AB;
   localparam logic [9:0] T10 = 10'h154;
   localparam logic [9:0] T11 = 10'h2AB;
`ifdef VIDEO_TMDS_ROUND_EN
   localparam logic [9:0] EXP_1FE = 10'h180;
`else
   localparam logic [9:0] EXP_1FE = 10'h280;
`endif

   logic          clk, rst_n, de_in, hs_in, vs_in;
   logic [CW-1:0] r_in, g_in, b_in;
   logic [9:0]    tmds_red, tmds_green, tmds_blue;
   logic          tmds_de;

   video_tmds_encoder #(.COLSPC(CW)) dut (
      .video_clk_pix (clk),
      .video_rst_n   (rst_n),
      .video_enable  (de_in),
      .hsync         (hs_in),
      .vsync         (vs_in),
      .red           (r_in),
      .green         (g_in),
      .blue          (b_in),
      .tmds_red      (tmds_red),
      .tmds_green    (tmds_green),
      .tmds_blue     (tmds_blue),
      .tmds_de       (tmds_de)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before the end of the test");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          de, hs, vs;
      logic [CW-1:0] r, g, b;
      logic [9:0]    er, eg, eb;
   } vec_t;

   vec_t vecs [10];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic de, input logic hs, input logic vs,
                        input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
      de_in = de; hs_in = hs; vs_in = vs;
      r_in = r; g_in = g; b_in = b;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] d2c(input logic [7:0] d);
      return {d, 2'b00};
   endfunction

   function automatic logic [7:0] ref_reduce(input logic [CW-1:0] c);
`ifdef VIDEO_TMDS_ROUND_EN
      int v;
      v = (int'(c) + 2) / 4;
      if (v > 255) v = 255;
      return 8'(v);
`else
      return c[CW-1:2];
`endif
   endfunction

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d    = '0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++)
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   // Behavioural DVI encoder for one channel, integer disparity bookkeeping.
   task automatic model_chan(input logic [7:0] d, input logic de, input logic [1:0] ctl,
                             inout int cnt, output logic [9:0] sym);
      int         n1d, n1q, n0q;
      logic       xn;
      logic [8:0] qm;
      n1d   = $countones(d);
      xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1q   = $countones(qm[7:0]);
      n0q   = 8 - n1q;
      if (!de) begin
         case (ctl)
            2'b00:   sym = T00;
            2'b01:   sym = T01;
            2'b10:   sym = T10;
            default: sym = T11;
         endcase
         cnt = 0;
      end else if (cnt == 0 || n1q == n0q) begin
         sym = {!qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         cnt = qm[8] ? cnt + n1q - n0q : cnt + n0q - n1q;
      end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
         sym = {1'b1, qm[8], ~qm[7:0]};
         cnt = cnt + 2 * int'(qm[8]) + n0q - n1q;
      end else begin
         sym = {1'b0, qm[8], qm[7:0]};
         cnt = cnt - 2 * int'(!qm[8]) + n1q - n0q;
      end
   endtask

   initial begin
      int            mc [3];
      logic          p_de, p_hs, p_vs;
      logic [CW-1:0] p_c [3];
      logic [CW-1:0] c [3];
      logic [9:0]    act [3];
      logic [9:0]    esym;
      logic [7:0]    d;
      int            cb [3];
      logic          de_n;

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) tick();
      check("rst_red", tmds_red, T00);
      check("rst_green", tmds_green, T00);
      check("rst_blue", tmds_blue, T00);
      check("rst_de", {9'b0, tmds_de}, 10'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      // Directed vectors: control tokens, then single active pixels from cnt = 0
      vecs[0] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, T00, T00, T00};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, T00, T00, T01};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, T00, T00, T10};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, T00, T00, T11};
      vecs[4] = '{1'b1, 1'b0, 1'b0, d2c(8'h00), d2c(8'hFF), d2c(8'h55), 10'h100, 10'h200, 10'h133};
      vecs[5] = '{1'b1, 1'b0, 1'b0, d2c(8'hAA), d2c(8'h01), d2c(8'h80), 10'h233, 10'h1FF, 10'h180};
      vecs[6] = '{1'b1, 1'b0, 1'b0, d2c(8'h10), 10'h1FE, 10'h3FF, 10'h1F0, EXP_1FE, 10'h200};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 10'h3FF, d2c(8'h55), d2c(8'hAA), 10'h200, 10'h133, 10'h233};
      vecs[8] = '{1'b1, 1'b0, 1'b0, d2c(8'h7F), 10'h1FE, d2c(8'h80), 10'h280, EXP_1FE, 10'h180};
      vecs[9] = '{1'b0, 1'b1, 1'b0, d2c(8'h55), d2c(8'h55), d2c(8'h55), T00, T00, T01};
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b);
         tick();
         drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
         tick();
         check($sformatf("vec%0d_red", i), tmds_red, vecs[i].er);
         check($sformatf("vec%0d_green", i), tmds_green, vecs[i].eg);
         check($sformatf("vec%0d_blue", i), tmds_blue, vecs[i].eb);
         check($sformatf("vec%0d_de", i), {9'b0, tmds_de}, {9'b0, vecs[i].de});
      end

      // DC balance: two zero pixels, blanking, then a zero pixel again from cnt = 0
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      tick();
      tick();
      check("dc_p1_green", tmds_green, 10'h100);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      check("dc_p2_green", tmds_green, 10'h3FF);
      check("dc_p2_red", tmds_red, 10'h3FF);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      tick();
      check("dc_blank_green", tmds_green, T00);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      check("dc_p3_green", tmds_green, 10'h100);
      repeat (2) tick();

      // Latency: single-cycle de pulse
      drive(1'b1, 1'b0, 1'b0, d2c(8'h55), d2c(8'h55), d2c(8'h55));
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 1) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
         check($sformatf("lat%0d_red", k), tmds_red, (k == 2) ? 10'h133 : T00);
         check($sformatf("lat%0d_green", k), tmds_green, (k == 2) ? 10'h133 : T00);
         check($sformatf("lat%0d_blue", k), tmds_blue, (k == 2) ? 10'h133 : T00);
         check($sformatf("lat%0d_de", k), {9'b0, tmds_de}, (k == 2) ? 10'd1 : 10'd0);
      end

      // Reset asserted mid-frame between edges, released between edges
      drive(1'b1, 1'b0, 1'b0, d2c(8'h55), d2c(8'h55), d2c(8'h55));
      repeat (3) tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mrst_red", tmds_red, T00);
      check("mrst_green", tmds_green, T00);
      check("mrst_blue", tmds_blue, T00);
      check("mrst_de", {9'b0, tmds_de}, 10'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("rel_e1_green", tmds_green, T00);
      check("rel_e1_de", {9'b0, tmds_de}, 10'd0);
      tick();
      tick();
      check("rel_e3_green", tmds_green, 10'h133);
      check("rel_e3_blue", tmds_blue, 10'h133);
      check("rel_e3_de", {9'b0, tmds_de}, 10'd1);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) tick();

      // Random soak against the behavioural model
      for (int ch = 0; ch < 3; ch++) mc[ch] = 0;
      p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
      for (int ch = 0; ch < 3; ch++) p_c[ch] = '0;
      for (int k = 0; k < 3000; k++) begin
         de_n = ((k % 800) >= 16) && ($urandom_range(0, 15) != 0);
         for (int ch = 0; ch < 3; ch++)
            c[ch] = ($urandom_range(0, 7) == 0) ? 10'h3FF : CW'($urandom_range(0, 1023));
         drive(de_n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c[2], c[1], c[0]);
         tick();
         if (k > 0) begin
            act[0] = tmds_blue; act[1] = tmds_green; act[2] = tmds_red;
            cb[0] = int'(dut.cnt_q[0]);
            cb[1] = int'(dut.cnt_q[1]);
            cb[2] = int'(dut.cnt_q[2]);
            check("soak_de", {9'b0, tmds_de}, {9'b0, p_de});
            for (int ch = 0; ch < 3; ch++) begin
               d = ref_reduce(p_c[ch]);
               model_chan(d, p_de, (ch == 0) ? {p_vs, p_hs} : 2'b00, mc[ch], esym);
               check($sformatf("soak%0d_ch%0d", k, ch), act[ch], esym);
               if (p_de) check($sformatf("soak%0d_dec%0d", k, ch), {2'b0, decode(act[ch])}, {2'b0, d});
               total++;
               if (cb[ch] > 10 || cb[ch] < -10 || cb[ch] != mc[ch]) begin
                  bad++;
                  $display("FAIL soak%0d_cnt%0d: got %0d expected %0d within +/-10", k, ch, cb[ch], mc[ch]);
               end
            end
         end
         p_de = de_in; p_hs = hs_in; p_vs = vs_in;
         for (int ch = 0; ch < 3; ch++) p_c[ch] = c[ch];
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
